// File: rtl/data_memory_pkg.sv
// Shared widths and access-size encoding for the data memory and its lane decoder.
package data_memory_pkg;

   localparam int DATA_W = 32;
   localparam int BYTE_W = 8;
   localparam int LANES  = 4;

   typedef enum logic {
      SIZE_WORD = 1'b0,
      SIZE_BYTE = 1'b1
   } access_size_e;

   // Which byte lanes an access touches; word accesses are always aligned.
   function automatic logic [LANES-1:0] lane_mask(input access_size_e size, input logic [1:0] lane);
      logic [LANES-1:0] mask;
      if (size == SIZE_WORD) mask = '1;
      else                   mask = 4'(1) << lane;
      return mask;
   endfunction

endpackage

// File: rtl/dm_byte_lane.sv
// Lane decode: per-lane write enables, write-data replication and load extraction/extension.
// Build option: DATA_MEMORY_SIGN_EXT_EN sign-extends byte loads (zero-extends when undefined).
module dm_byte_lane
   import data_memory_pkg::*;
(
   input  access_size_e      i_size,
   input  logic [1:0]        i_lane,
   input  logic              i_we,
   input  logic              i_re,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [DATA_W-1:0] i_rword,
   output logic [LANES-1:0]  o_lane_we,
   output logic [DATA_W-1:0] o_wword,
   output logic [DATA_W-1:0] o_rdata
);

   logic [BYTE_W-1:0] w_byte;
   logic [DATA_W-1:0] w_ext;

   assign w_byte = i_rword[{i_lane, 3'b000} +: BYTE_W];

`ifdef DATA_MEMORY_SIGN_EXT_EN
   assign w_ext = {{(DATA_W-BYTE_W){w_byte[BYTE_W-1]}}, w_byte};
`else
   assign w_ext = {{(DATA_W-BYTE_W){1'b0}}, w_byte};
`endif

   always_comb begin
      o_lane_we = '0;
      o_wword   = i_wdata;
      o_rdata   = '0;
      // Byte stores replicate the low byte so every lane sees it; only the enabled lane commits.
      if (i_size == SIZE_BYTE) o_wword = {LANES{i_wdata[BYTE_W-1:0]}};
      if (i_we) o_lane_we = lane_mask(i_size, i_lane);
      if (i_re) o_rdata = (i_size == SIZE_WORD) ? i_rword : w_ext;
   end

endmodule

// File: rtl/data_memory.sv
// Byte-addressed little-endian data memory: combinational read, write and reset on clk rising edge.
// Build option: DATA_MEMORY_SIGN_EXT_EN selects sign-extended byte loads (zero-extended otherwise).
module data_memory
   import data_memory_pkg::*;
#(
   parameter int          DEPTH_WORDS = 256,
   parameter logic [31:0] INIT_VALUE  = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] address,
   input  logic [DATA_W-1:0] write_data,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic              byte_sel,   // access size select; "byte" is a reserved word
   output logic [DATA_W-1:0] read_data
);

   localparam int AW = $clog2(DEPTH_WORDS);

   logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

   access_size_e      w_size;
   logic [AW-1:0]     w_word_idx;
   logic [1:0]        w_lane;
   logic [DATA_W-1:0] w_rword;
   logic [LANES-1:0]  w_lane_we;
   logic [DATA_W-1:0] w_wword;
   logic              w_unused_addr;

   assign w_size     = byte_sel ? SIZE_BYTE : SIZE_WORD;
   assign w_word_idx = address[AW+1:2];
   assign w_lane     = (w_size == SIZE_BYTE) ? address[1:0] : 2'b00;
   assign w_rword    = r_mem[w_word_idx];

   // Upper address bits are dropped so accesses wrap around the array.
   assign w_unused_addr = &{1'b0, address[DATA_W-1:AW+2]};

   dm_byte_lane u_lane (
      .i_size    (w_size),
      .i_lane    (w_lane),
      .i_we      (MemWrite),
      .i_re      (MemRead),
      .i_wdata   (write_data),
      .i_rword   (w_rword),
      .o_lane_we (w_lane_we),
      .o_wword   (w_wword),
      .o_rdata   (read_data)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH_WORDS; i++) r_mem[i] <= INIT_VALUE;
      end else begin
         for (int l = 0; l < LANES; l++) begin
            if (w_lane_we[l]) r_mem[w_word_idx][l*BYTE_W +: BYTE_W] <= w_wword[l*BYTE_W +: BYTE_W];
         end
      end
   end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed cases plus random traffic against a byte-array model.
module tb_data_memory;

   localparam int          DEPTH = 64;
   localparam int          BYTES = DEPTH * 4;
   localparam logic [31:0] INIT  = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] address;
   logic [31:0] write_data;
   logic        MemRead;
   logic        MemWrite;
   logic        byte_sel;
   logic [31:0] read_data;

   int n_pass = 0;
   int n_total = 0;

   logic [7:0] m_mem [BYTES];

   always #5 clk = ~clk;

   data_memory #(.DEPTH_WORDS(DEPTH), .INIT_VALUE(INIT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .address    (address),
      .write_data (write_data),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .byte_sel   (byte_sel),
      .read_data  (read_data)
   );

   function automatic logic [31:0] ref_read(input logic [31:0] a, input logic b);
      int unsigned idx;
      logic [7:0]  v;
      idx = a % BYTES;
      if (!b) begin
         idx = idx - (idx % 4);
         return {m_mem[idx+3], m_mem[idx+2], m_mem[idx+1], m_mem[idx]};
      end
      v = m_mem[idx];
`ifdef DATA_MEMORY_SIGN_EXT_EN
      return v[7] ? (32'hFFFF_FF00 | 32'(v)) : 32'(v);
`else
      return 32'(v);
`endif
   endfunction

   function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input logic b);
      int unsigned idx;
      idx = a % BYTES;
      if (b) m_mem[idx] = d[7:0];
      else begin
         idx = idx - (idx % 4);
         for (int k = 0; k < 4; k++) m_mem[idx+k] = d[8*k +: 8];
      end
   endfunction

   function automatic void ref_reset();
      for (int w = 0; w < DEPTH; w++)
         for (int k = 0; k < 4; k++) m_mem[4*w+k] = INIT[8*k +: 8];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic b);
      @(negedge clk);
      MemRead = 1'b0; MemWrite = 1'b1; address = a; write_data = d; byte_sel = b;
      @(posedge clk);
      #1;
      MemWrite = 1'b0;
      ref_write(a, d, b);
   endtask

   task automatic do_read(input string tag, input logic [31:0] a, input logic b);
      @(negedge clk);
      MemWrite = 1'b0; MemRead = 1'b1; address = a; byte_sel = b;
      #1;
      check(tag, read_data, ref_read(a, b));
      MemRead = 1'b0;
   endtask

   task automatic read_const(input string tag, input logic [31:0] a, input logic b, input logic [31:0] exp);
      @(negedge clk);
      MemWrite = 1'b0; MemRead = 1'b1; address = a; byte_sel = b;
      #1;
      check(tag, read_data, exp);
      MemRead = 1'b0;
   endtask

   initial begin
      logic [31:0] a, d, old;
      logic        b;
      int          op;

      rst_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; byte_sel = 1'b0;
      address = '0; write_data = '0;

      // reset clear
      @(posedge clk); #1;
      rst_n = 1'b1;
      ref_reset();
      read_const("reset_clear", 32'h1, 1'b0, 32'h0000_0000);

      // aligned word write/read
      do_write(32'h7, 32'h1, 1'b0);
      read_const("word_rd_4", 32'h4, 1'b0, 32'h0000_0001);
      read_const("word_rd_7", 32'h7, 1'b0, 32'h0000_0001);

      // byte merge into existing word
      do_write(32'h0, 32'h1122_3344, 1'b0);
      do_write(32'h2, 32'h0000_00AB, 1'b1);
      read_const("merge_word", 32'h0, 1'b0, 32'h11AB_3344);
`ifdef DATA_MEMORY_SIGN_EXT_EN
      read_const("merge_byte", 32'h2, 1'b1, 32'hFFFF_FFAB);
`else
      read_const("merge_byte", 32'h2, 1'b1, 32'h0000_00AB);
`endif
      read_const("merge_lane0", 32'h0, 1'b1, 32'h0000_0044);

      // top lane
      do_write(32'hF, 32'h2, 1'b1);
      read_const("top_byte", 32'hF, 1'b1, 32'h0000_0002);
      read_const("top_word", 32'hC, 1'b0, 32'h0200_0000);

      // read gating and address wrap
      @(negedge clk);
      MemRead = 1'b0; address = 32'h0; byte_sel = 1'b0;
      #1 check("gate_off", read_data, 32'h0);
      do_write(DEPTH * 4, 32'hDEAD_BEEF, 1'b0);
      read_const("wrap_word", 32'h0, 1'b0, 32'hDEAD_BEEF);

      // simultaneous read and write: old data before edge, new after
      @(negedge clk);
      MemRead = 1'b1; MemWrite = 1'b1; address = 32'h20; byte_sel = 1'b0; write_data = 32'hCAFE_F00D;
      old = ref_read(32'h20, 1'b0);
      #1 check("rw_before", read_data, old);
      @(posedge clk); #1;
      ref_write(32'h20, 32'hCAFE_F00D, 1'b0);
      check("rw_after", read_data, 32'hCAFE_F00D);
      MemWrite = 1'b0; MemRead = 1'b0;

      // undefined write data with MemWrite low must not disturb storage
      @(negedge clk);
      MemWrite = 1'b0; address = 32'h20; write_data = 'x; byte_sel = 1'b0;
      @(posedge clk); #1;
      write_data = '0;
      read_const("x_ignored", 32'h20, 1'b0, 32'hCAFE_F00D);

      // reset beats a same-cycle write; reads stay live during reset
      @(negedge clk);
      rst_n = 1'b0; MemWrite = 1'b1; MemRead = 1'b1; address = 32'h0; write_data = 32'h5; byte_sel = 1'b0;
      #1 check("rst_read_old", read_data, 32'hDEAD_BEEF);
      @(posedge clk); #1;
      check("rst_read_new", read_data, INIT);
      rst_n = 1'b1; MemWrite = 1'b0; MemRead = 1'b0;
      ref_reset();
      read_const("rst_priority", 32'h0, 1'b0, INIT);

      // random traffic
      for (int k = 0; k < 400; k++) begin
         a  = $urandom;
         d  = $urandom;
         b  = 1'($urandom_range(0, 1));
         op = $urandom_range(0, 3);
         if (op < 2) do_write(a, d, b);
         else if (op == 2) do_read("rand_rd", a, b);
         else begin
            @(negedge clk);
            MemRead = 1'b0; address = a; byte_sel = b;
            #1 check("rand_gate", read_data, 32'h0);
         end
      end

      for (int w = 0; w < DEPTH; w++) do_read("sweep", 32'(4 * w), 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning storage depth in 32-bit words (power of two, >= 4).
REQ-002 SHALL have parameter INIT_VALUE, default 32'h0000_0000, meaning the word value loaded into every location on reset.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port address, input, 32 bits: byte address.
REQ-006 SHALL have port write_data, input, 32 bits: store data; only bits [7:0] are used in byte mode.
REQ-007 SHALL have port MemRead, input, 1 bit: read enable.
REQ-008 SHALL have port MemWrite, input, 1 bit: write enable.
REQ-009 SHALL have port byte, input, 1 bit: access size select; 1 = byte, 0 = 32-bit word.
REQ-010 SHALL have port read_data, output, 32 bits: load result.

Function
REQ-011 SHALL store data byte-addressed and little-endian: word index = address[log2(DEPTH_WORDS)+1:2], lane = address[1:0].
REQ-012 SHALL ignore upper address bits, so accesses wrap modulo DEPTH_WORDS*4 bytes; no error is flagged.
REQ-013 SHALL, for word access (byte=0), force address[1:0] to 00 (aligned word; misalignment silently truncated).
REQ-014 SHALL read combinationally (zero latency): read_data reflects the current address, byte and stored contents whenever MemRead=1.
REQ-015 SHALL drive read_data = 32'h0 whenever MemRead=0.
REQ-016 SHALL, for a word read, return the full word; for a byte read, return the addressed byte in [7:0] with upper bits extended per REQ-025.
REQ-017 SHALL write on the rising clk edge when MemWrite=1 and rst_n=1: a word write updates all 4 lanes; a byte write updates only the addressed lane with write_data[7:0] and leaves the other 3 lanes unchanged.
REQ-018 SHALL, when MemRead and MemWrite are both 1 to the same location, show old data before the edge and new data after it (no write-through bypass).
REQ-019 SHALL allow MemRead and MemWrite to be set independently; no handshake and no busy state.
REQ-020 SHALL ignore X/undefined values on write_data when MemWrite=0.

Reset
REQ-021 SHALL, on a rising clk edge with rst_n=0, load INIT_VALUE into every word location.
REQ-022 SHALL give reset priority over MemWrite in the same cycle; the write is discarded.
REQ-023 SHALL keep read_data combinational during reset: 0 if MemRead=0, otherwise the contents as of the last edge.
REQ-024 SHALL have no output register, so read_data has no separate reset value beyond REQ-015 and REQ-023.

Configuration
REQ-025 SHALL use macro DATA_MEMORY_SIGN_EXT_EN: when defined, byte reads sign-extend bit 7 into [31:8]; when undefined, byte reads zero-extend. Word behaviour is identical in both builds.

Structure
REQ-026 SHALL place in shared package data_memory_pkg: DATA_W=32, BYTE_W=8, LANES=4, and an access-size enumeration (SIZE_WORD, SIZE_BYTE).
REQ-027 SHALL implement lane decode (per-lane write enables, byte extraction and extension) in one sub-module, dm_byte_lane; the storage array lives in data_memory.

Verification
REQ-028 SHALL test reset clear: rst_n=0 for 1 edge, then MemRead=1, byte=0, address=32'h1 -> read_data=32'h0000_0000.
REQ-029 SHALL test word write/read: MemWrite=1, byte=0, address=32'h7, write_data=32'h1 for 1 edge; then read address 32'h4 -> 32'h0000_0001; read address 32'h7 -> 32'h0000_0001 (aligned).
REQ-030 SHALL test byte merge: word 0x0 = 32'h1122_3344; byte write address 32'h2, data 32'hAB -> word read 32'h11AB_3344; byte read address 32'h2 -> 32'h0000_00AB (zero-extended) or 32'hFFFF_FFAB with DATA_MEMORY_SIGN_EXT_EN.
REQ-031 SHALL test byte at top lane: byte write address 32'hF, data 32'h2 -> byte read address 32'hF = 32'h2; word read address 32'hC = 32'h0200_0000.
REQ-032 SHALL test gating and wrap: MemRead=0 -> read_data=0; write 32'hDEAD_BEEF at address DEPTH_WORDS*4 -> word read at address 0 = 32'hDEAD_BEEF.
REQ-033 SHALL test reset priority: rst_n=0 together with MemWrite=1 (address 32'h0, data 32'h5) -> word 0 reads INIT_VALUE afterwards.
